// File: rtl/nmi_apb_pkg.sv
// nmi_apb_pkg: shared types and helpers for the NMI-to-APB bridge
package nmi_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_SLV = 2'd1, ERR_TMO = 2'd2, ERR_DEC = 2'd3} err_code_e;
  function automatic int slv_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/nmi_apb_decoder.sv
// nmi_apb_decoder: base/mask address decode, lowest matching slot wins
module nmi_apb_decoder
  import nmi_apb_pkg::*;
#(
  parameter int                    NUM_SLV  = 8,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK = {NUM_SLV{32'hFFFF_F000}},
  parameter int                    IW       = slv_idx_w(NUM_SLV)
) (
  input  logic [31:0]        i_addr,
  output logic               o_hit,
  output logic [IW-1:0]      o_idx,
  output logic [NUM_SLV-1:0] o_sel
);
  // scan from the top so the lowest matching slot is the last to overwrite
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((i_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        o_hit = 1'b1;
        o_idx = IW'(i);
      end
  end

  assign o_sel = o_hit ? (NUM_SLV'(1) << o_idx) : '0;
endmodule

// File: rtl/nmi_apb_bridge.sv
// nmi_apb_bridge: NMI request to APB4 transfer with decode, timeout and error capture
module nmi_apb_bridge
  import nmi_apb_pkg::*;
#(
  parameter int                    NUM_SLV     = 8,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {NUM_SLV{32'hFFFF_F000}},
  parameter int                    TIMEOUT_CYC = 255,
  parameter logic [31:0]           ERR_RDATA   = 32'hDEAD_BEEF,
  parameter logic [2:0]            PPROT_VAL   = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mem_valid_i,
  input  logic [31:0]             mem_addr_i,
  input  logic [31:0]             mem_wdata_i,
  input  logic [3:0]              mem_wstrb_i,
  output logic [31:0]             mem_rdata_o,
  output logic                    mem_ready_o,
  output logic [31:0]             apb_paddr_o,
  output logic [2:0]              apb_pprot_o,
  output logic [NUM_SLV-1:0]      apb_psel_o,
  output logic                    apb_penable_o,
  output logic                    apb_pwrite_o,
  output logic [31:0]             apb_pwdata_o,
  output logic [3:0]              apb_pstrb_o,
  input  logic [NUM_SLV-1:0]      apb_pready_i,
  input  logic [NUM_SLV*32-1:0]   apb_prdata_i,
  input  logic [NUM_SLV-1:0]      apb_pslverr_i,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output logic [31:0]             err_addr_o
);
  localparam int IW = slv_idx_w(NUM_SLV);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e               r_state;
  logic [IW-1:0]        r_idx;
  logic [CW-1:0]        r_cnt;
  logic [NUM_SLV-1:0]   r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [31:0]          r_paddr;
  logic [31:0]          r_pwdata;
  logic [3:0]           r_pstrb;
  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic                 r_err;
  err_code_e            r_err_code;
  logic [31:0]          r_err_addr;

  logic                 w_hit;
  logic [IW-1:0]        w_idx;
  logic [NUM_SLV-1:0]   w_sel;
  logic                 w_pready;
  logic                 w_pslverr;
  logic [31:0]          w_prdata;
  logic                 w_tmo;
  logic                 w_fail;

  nmi_apb_decoder #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IW       (IW)
  ) u_dec (
    .i_addr (mem_addr_i),
    .o_hit  (w_hit),
    .o_idx  (w_idx),
    .o_sel  (w_sel)
  );

  assign w_pready    = apb_pready_i[r_idx];
  assign w_pslverr   = apb_pslverr_i[r_idx];
  assign w_prdata    = apb_prdata_i[{r_idx, 5'b0} +: 32];
  assign w_tmo       = (TIMEOUT_CYC > 0) && (r_cnt == TMO_LAST);
  assign w_fail      = !w_pready || w_pslverr;

  assign mem_rdata_o   = r_rdata;
  assign mem_ready_o   = r_ready;
  assign apb_paddr_o   = r_paddr;
  assign apb_pprot_o   = PPROT_VAL;
  assign apb_psel_o    = r_psel;
  assign apb_penable_o = r_penable;
  assign apb_pwrite_o  = r_pwrite;
  assign apb_pwdata_o  = r_pwdata;
  assign apb_pstrb_o   = r_pstrb;
  assign err_o         = r_err;
  assign err_code_o    = r_err_code;
  assign err_addr_o    = r_err_addr;

  // transfer FSM; every output is registered on the transition into its state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_addr <= '0;
    end else begin
      case (r_state)
        IDLE: if (mem_valid_i) begin
          if (w_hit) begin
            r_state  <= SETUP;
            r_idx    <= w_idx;
            r_psel   <= w_sel;
            r_paddr  <= mem_addr_i;
            r_pwdata <= mem_wdata_i;
            r_pstrb  <= mem_wstrb_i;
            r_pwrite <= |mem_wstrb_i;
          end else begin
            r_state    <= RESP;
            r_ready    <= 1'b1;
            r_rdata    <= ERR_RDATA;
            r_err      <= 1'b1;
            r_err_code <= ERR_DEC;
            r_err_addr <= mem_addr_i;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_cnt     <= '0;
        end
        ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_pready || w_tmo) begin
            r_state   <= RESP;
            r_ready   <= 1'b1;
            r_err     <= w_fail;
            r_rdata   <= w_fail ? ERR_RDATA : (r_pwrite ? '0 : w_prdata);
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            if (w_fail) begin
              r_err_code <= w_pready ? ERR_SLV : ERR_TMO;
              r_err_addr <= r_paddr;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
